// File: rtl/pc_sched.sv
// Next-PC scheduler: owns the fetch PC and arbitrates exception, eret, branch and sequential fetch.
// Redirects that arrive during a fetch stall are parked in a one-deep pending slot.
module pc_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic        adel_if,
  output logic        flush,
  output logic        pend,
  output logic [15:0] redir_cnt
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic [31:0] pc_nxt;
  logic        flush_nxt;
  logic        cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      pend_addr <= 32'h0;
      flush     <= 1'b0;
      redir_cnt <= 16'h0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      pend_addr <= pend_addr_nxt;
      flush     <= flush_nxt;
      if (cnt_inc) redir_cnt <= redir_cnt + 16'd1;
    end
  end

  // Priority: exception > eret > parked redirect > branch > sequential.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pend_addr_nxt = pend_addr;
    flush_nxt     = 1'b0;
    cnt_inc       = 1'b0;
    if (exc_req) begin
      pc_nxt    = EXC_PC;
      state_nxt = RUN;
      flush_nxt = 1'b1;
      cnt_inc   = 1'b1;
    end else if (eret_req) begin
      if (en) begin
        pc_nxt    = epc;
        state_nxt = RUN;
        flush_nxt = 1'b1;
        cnt_inc   = 1'b1;
      end else begin
        pend_addr_nxt = epc;
        state_nxt     = PEND;
      end
    end else if (state == PEND) begin
      // br_valid here comes from the same stalled instruction, so it is ignored.
      if (en) begin
        pc_nxt    = pend_addr;
        state_nxt = RUN;
        cnt_inc   = 1'b1;
      end
    end else if (br_valid) begin
      if (en) begin
        pc_nxt  = br_target;
        cnt_inc = 1'b1;
      end else begin
        pend_addr_nxt = br_target;
        state_nxt     = PEND;
      end
    end else if (en) begin
      pc_nxt = pc + 32'd4;
    end
  end

  assign pend    = (state == PEND);
  assign adel_if = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

endmodule

// File: tb/tb_pc_sched.sv
// Directed table-driven bench for pc_sched plus hand-written async-reset and counter-wrap sequences.
module tb_pc_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, br_valid, eret_req, exc_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc;
  logic        adel_if, flush, pend;
  logic [15:0] redir_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sched dut (
    .clk(clk), .reset(reset), .en(en), .br_valid(br_valid), .br_target(br_target),
    .eret_req(eret_req), .epc(epc), .exc_req(exc_req), .pc(pc), .adel_if(adel_if),
    .flush(flush), .pend(pend), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        br;
    logic [31:0] tgt;
    logic        eret;
    logic [31:0] epc;
    logic        exc;
    logic [31:0] e_pc;
    logic        e_pend;
    logic        e_flush;
    logic [15:0] e_cnt;
    logic        e_adel;
  } vec_t;

  vec_t vt[30];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_pend,
                           input logic e_flush, input logic [15:0] e_cnt, input logic e_adel);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " pend"}, {31'b0, pend}, {31'b0, e_pend});
    check({tag, " flush"}, {31'b0, flush}, {31'b0, e_flush});
    check({tag, " redir_cnt"}, {16'b0, redir_cnt}, {16'b0, e_cnt});
    check({tag, " adel_if"}, {31'b0, adel_if}, {31'b0, e_adel});
  endtask

  task automatic drive(input logic e, input logic b, input logic [31:0] t,
                       input logic r, input logic [31:0] p, input logic x);
    en = e; br_valid = b; br_target = t; eret_req = r; epc = p; exc_req = x;
  endtask

  function automatic vec_t mk(logic e, logic b, logic [31:0] t, logic r, logic [31:0] p, logic x,
                              logic [31:0] epc_o, logic pd, logic fl, logic [15:0] c, logic ad);
    vec_t v;
    v.en = e; v.br = b; v.tgt = t; v.eret = r; v.epc = p; v.exc = x;
    v.e_pc = epc_o; v.e_pend = pd; v.e_flush = fl; v.e_cnt = c; v.e_adel = ad;
    return v;
  endfunction

  initial begin
    //           en br tgt           eret epc          exc  pc            pend fl cnt ad
    vt[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0, 0, 0,  0);
    vt[1]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 0, 0, 0,  0);
    vt[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_300C, 0, 0, 0,  0);
    vt[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3010, 0, 0, 0,  0);
    vt[4]  = mk(1, 1, 32'h3400,     0, 32'h0,        0, 32'h0000_3400, 0, 0, 1,  0);
    vt[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3404, 0, 0, 1,  0);
    vt[6]  = mk(0, 1, 32'h3500,     0, 32'h0,        0, 32'h0000_3404, 1, 0, 1,  0);
    vt[7]  = mk(0, 1, 32'h3600,     0, 32'h0,        0, 32'h0000_3404, 1, 0, 1,  0);
    vt[8]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3404, 1, 0, 1,  0);
    vt[9]  = mk(1, 1, 32'h3700,     0, 32'h0,        0, 32'h0000_3500, 0, 0, 2,  0);
    vt[10] = mk(0, 1, 32'h3800,     0, 32'h0,        0, 32'h0000_3500, 1, 0, 2,  0);
    vt[11] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4180, 0, 1, 3,  0);
    vt[12] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4184, 0, 0, 3,  0);
    vt[13] = mk(1, 0, 32'h0,        1, 32'h3024,     1, 32'h0000_4180, 0, 1, 4,  0);
    vt[14] = mk(1, 0, 32'h0,        1, 32'h3024,     0, 32'h0000_3024, 0, 1, 5,  0);
    vt[15] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3028, 0, 0, 5,  0);
    vt[16] = mk(0, 0, 32'h0,        1, 32'h3100,     0, 32'h0000_3028, 1, 0, 5,  0);
    vt[17] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3100, 0, 0, 6,  0);
    vt[18] = mk(1, 1, 32'h3002,     0, 32'h0,        0, 32'h0000_3002, 0, 0, 7,  1);
    vt[19] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3006, 0, 0, 7,  1);
    vt[20] = mk(1, 1, 32'h7000,     0, 32'h0,        0, 32'h0000_7000, 0, 0, 8,  1);
    vt[21] = mk(1, 1, 32'h3000,     0, 32'h0,        0, 32'h0000_3000, 0, 0, 9,  0);
    vt[22] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0, 0, 9,  0);
    vt[23] = mk(1, 1, 32'h6FFC,     0, 32'h0,        0, 32'h0000_6FFC, 0, 0, 10, 0);
    vt[24] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_7000, 0, 0, 10, 1);
    vt[25] = mk(0, 1, 32'h3200,     0, 32'h0,        0, 32'h0000_7000, 1, 0, 10, 1);
    vt[26] = mk(0, 0, 32'h0,        1, 32'h3300,     0, 32'h0000_7000, 1, 0, 10, 1);
    vt[27] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3300, 0, 0, 11, 0);
    vt[28] = mk(1, 1, 32'h2FFC,     0, 32'h0,        0, 32'h0000_2FFC, 0, 0, 12, 1);
    vt[29] = mk(1, 1, 32'h3000,     0, 32'h0,        0, 32'h0000_3000, 0, 0, 13, 0);

    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    #23;
    check_all("reset", 32'h0000_3000, 0, 0, 16'd0, 0);
    reset = 1'b0;

    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      drive(vt[i].en, vt[i].br, vt[i].tgt, vt[i].eret, vt[i].epc, vt[i].exc);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_pend, vt[i].e_flush,
                vt[i].e_cnt, vt[i].e_adel);
    end

    // Park a branch, then hit reset asynchronously between edges.
    drive(0, 1, 32'h3400, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_all("park_before_reset", 32'h0000_3000, 1, 0, 16'd13, 0);
    drive(0, 1, 32'h3400, 0, 32'h0, 0);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0000_3000, 0, 0, 16'd0, 0);
    #1 reset = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_all("post_reset_stall", 32'h0000_3000, 0, 0, 16'd0, 0);
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk); #1;
    check_all("post_reset_run", 32'h0000_3004, 0, 0, 16'd0, 0);

    // Counter wrap: 65535 more redirects reach FFFF, one more wraps to 0.
    drive(1, 1, 32'h3000, 0, 32'h0, 0);
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check("cnt_max", {16'b0, redir_cnt}, 32'h0000_FFFF);
    @(posedge clk); #1;
    check("cnt_wrap", {16'b0, redir_cnt}, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
